mips_alu_issue: RTL and testbench
=================================

# mips_alu_issue

Issue stage directly upstream of the 32-bit ALU. Accepts MIPS instruction words with their already-read register operands over a valid/ready handshake. Decodes each one into the ALU's 3-bit opcode plus A/B operands and a destination tag. Decoded beats are held in a 2-entry output buffer that feeds the ALU and the writeback path.

## Interface
- `DEPTH`, 2 — output buffer entries (fixed at 2; the parameter exists only for bench visibility)
- `CNT_W`, 16 — width of the issued-beat counter
- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `in_valid` in 1 — upstream beat valid
- `in_ready` out 1 — stage can accept a beat this cycle
- `in_instr` in 32 — MIPS instruction word
- `in_rs_val` in 32 — value of register rs
- `in_rt_val` in 32 — value of register rt
- `out_valid` out 1 — head entry valid toward the ALU
- `out_ready` in 1 — ALU/writeback consumes the head entry
- `alu_op` out 3 — ALU opcode
- `alu_a` out 32 — ALU operand A
- `alu_b` out 32 — ALU operand B
- `out_rd` out 5 — destination register tag
- `out_illegal` out 1 — head entry is an illegal instruction (only when `ILLEGAL_TRAP_EN` is defined; otherwise tied 0)
- `issued_cnt` out CNT_W — number of beats popped; wraps modulo 2^CNT_W

## Operation
- ALU opcodes (package constants):
  - SLA = 000, SRAI = 001, ADD = 010, SUB = 011
  - AND = 100, OR = 101, SLT = 110, XOR = 111
- R-type (instr[31:26] = 0): operands A = rs, B = rt, rd = instr[15:11]. Decode by funct:
  - 0x20 → ADD, 0x22 → SUB, 0x24 → AND, 0x25 → OR, 0x26 → XOR, 0x2A → SLT
  - 0x00 (sll) → SLA, with A = rt and B = zero-extended shamt instr[10:6]
  - 0x03 (sra) → SRAI, with A = rt and B = zero-extended shamt instr[10:6]
- I-type: A = rs, rd = instr[20:16]. B is the immediate, extended as follows:
  - sign-extended: addi 0x08 → ADD; slti 0x0A → SLT
  - zero-extended: andi 0x0C → AND; ori 0x0D → OR; xori 0x0E → XOR
- Any other opcode/funct pair is illegal. Its handling depends on `ILLEGAL_TRAP_EN` (see Configuration).
- Accept: `in_valid && in_ready` at a rising edge. The decoded entry is written at the buffer tail.
- Pop: `out_valid && out_ready` at a rising edge. The head entry is retired and `issued_cnt` increments.
- Buffer:
  - 2-entry circular buffer with a 1-bit write pointer, a 1-bit read pointer and a 2-bit count.
  - `out_valid` = (count ≠ 0).
  - All `alu_*`, `out_rd` and `out_illegal` outputs come from the head entry.
- `in_ready` is registered and equals (next count < 2). There is no combinational path from `out_ready` to `in_ready`.
- Boundary cases:
  - count = 2: `in_ready` = 0. Upstream holds its beat; a pop in this cycle raises `in_ready` for the next cycle.
  - count = 1 with push and pop in the same cycle: count stays 1 and the pointers both advance.
  - count = 0: no pop occurs regardless of `out_ready`.
  - While `out_valid` = 1 and `out_ready` = 0, head outputs stay stable.
- Reset, at any time including mid-transfer:
  - count = 0, pointers = 0, `issued_cnt` = 0
  - `out_valid` = 0; `alu_op`, `alu_a`, `alu_b`, `out_rd`, `out_illegal` = 0
  - `in_ready` = 0
  - Buffered entries are discarded.

## Timing
- Latency: a beat accepted at edge N is presented with `out_valid` = 1 after edge N, i.e. one cycle, provided the buffer was empty.
- Throughput: 1 beat per cycle when `out_ready` is held high.
- `in_ready` rises at the first rising edge after `rst_n` deasserts.
- Decode is combinational on the input side. All outputs are registered and change only on rising edges, except on asynchronous reset.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - Illegal instructions are accepted and enqueued with `out_illegal` = 1, `alu_op` = ADD, A = B = 0 and rd = 0.
  - They count toward `issued_cnt` when popped.
- `ILLEGAL_TRAP_EN` undefined:
  - Illegal instructions are accepted (handshake completes) but not enqueued, so no output beat is produced.
  - `out_illegal` is constant 0.

## Structure
- Package `mips_alu_pkg`: ALU opcode localparams (shared with the ALU), MIPS opcode/funct constants, and a packed struct for the decoded entry {op, a, b, rd, illegal}.
- Sub-module `mips_alu_decode`: purely combinational instruction → entry decode. The top level holds the buffer, handshake and counter.

## Test plan
- **Reset:** hold `rst_n` = 0 mid-stream with 2 entries buffered → all outputs 0 and `in_ready` = 0. After release, `in_ready` = 1 on the next edge.
- **R-type shift:** sll with rt = 0xDDDDDDDD and shamt = 1 → `alu_op` = 000, A = 0xDDDDDDDD, B = 1, rd = instr[15:11], one cycle after accept.
- **I-type extension:** addi with imm = 0xFFFF and rs = 5 → ADD, A = 5, B = 0xFFFFFFFF. Then ori with imm = 0xFFFF → OR, B = 0x0000FFFF.
- **Backpressure:** `out_ready` = 0, push 3 beats → `in_ready` drops after the 2nd accept and the 3rd is held. Raise `out_ready` → beats drain in order and `issued_cnt` = 3.
- **Streaming:** `out_ready` = 1 with back-to-back srai/sub/slt → one output per cycle in order, count never exceeds 1.
- **Illegal instruction** (opcode 0x3F): with `ILLEGAL_TRAP_EN` → one beat with `out_illegal` = 1. Without it → no output beat, and `issued_cnt` is unchanged.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS ALU issue stage and the ALU itself.
// Holds the ALU opcode encodings, the MIPS opcode/funct constants, the decoded
// buffer entry struct and the immediate-extension helpers.
package mips_alu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 3;

    // ALU opcodes, shared with the ALU
    localparam logic [OP_W-1:0] ALU_SLA  = 3'b000;
    localparam logic [OP_W-1:0] ALU_SRAI = 3'b001;
    localparam logic [OP_W-1:0] ALU_ADD  = 3'b010;
    localparam logic [OP_W-1:0] ALU_SUB  = 3'b011;
    localparam logic [OP_W-1:0] ALU_AND  = 3'b100;
    localparam logic [OP_W-1:0] ALU_OR   = 3'b101;
    localparam logic [OP_W-1:0] ALU_SLT  = 3'b110;
    localparam logic [OP_W-1:0] ALU_XOR  = 3'b111;

    // MIPS primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;

    // MIPS R-type funct codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Decoded beat as stored in the output buffer
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [REG_W-1:0] rd;
        logic             illegal;
    } entry_t;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [XLEN-1:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational MIPS instruction -> ALU entry decode.
// Ports: instr (32b instruction), rs_val/rt_val (register operands),
//        ent (decoded entry; illegal=1 with ADD/0/0/rd=0 for unknown encodings).
module mips_alu_decode
    import mips_alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output entry_t      ent
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rd_r;
    logic [4:0]  rd_i;
    logic [15:0] imm;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign shamt  = instr[10:6];
    assign rd_r   = instr[15:11];
    assign rd_i   = instr[20:16];
    assign imm    = instr[15:0];

    // The rs index field is not needed: its value arrives already read.
    logic unused_rs_idx;
    assign unused_rs_idx = ^instr[25:21];

    // Opcode/funct decode; anything unmatched keeps the illegal default
    always_comb begin
        ent         = '0;
        ent.op      = ALU_ADD;
        ent.illegal = 1'b1;
        unique case (opcode)
            OPC_RTYPE: begin
                ent.a  = rs_val;
                ent.b  = rt_val;
                ent.rd = rd_r;
                ent.illegal = 1'b0;
                unique case (funct)
                    FN_ADD: ent.op = ALU_ADD;
                    FN_SUB: ent.op = ALU_SUB;
                    FN_AND: ent.op = ALU_AND;
                    FN_OR:  ent.op = ALU_OR;
                    FN_XOR: ent.op = ALU_XOR;
                    FN_SLT: ent.op = ALU_SLT;
                    FN_SLL: begin
                        ent.op = ALU_SLA;
                        ent.a  = rt_val;
                        ent.b  = 32'(shamt);
                    end
                    FN_SRA: begin
                        ent.op = ALU_SRAI;
                        ent.a  = rt_val;
                        ent.b  = 32'(shamt);
                    end
                    default: begin
                        ent         = '0;
                        ent.op      = ALU_ADD;
                        ent.illegal = 1'b1;
                    end
                endcase
            end
            OPC_ADDI: begin
                ent = '{op: ALU_ADD, a: rs_val, b: sext16(imm), rd: rd_i, illegal: 1'b0};
            end
            OPC_SLTI: begin
                ent = '{op: ALU_SLT, a: rs_val, b: sext16(imm), rd: rd_i, illegal: 1'b0};
            end
            OPC_ANDI: begin
                ent = '{op: ALU_AND, a: rs_val, b: zext16(imm), rd: rd_i, illegal: 1'b0};
            end
            OPC_ORI: begin
                ent = '{op: ALU_OR, a: rs_val, b: zext16(imm), rd: rd_i, illegal: 1'b0};
            end
            OPC_XORI: begin
                ent = '{op: ALU_XOR, a: rs_val, b: zext16(imm), rd: rd_i, illegal: 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_alu_issue.sv
// Issue stage in front of the 32-bit ALU: decodes MIPS instructions and holds
// decoded beats in a 2-entry output buffer toward the ALU/writeback path.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_instr/in_rs_val/
//        in_rt_val (upstream); out_valid/out_ready/alu_op/alu_a/alu_b/out_rd/
//        out_illegal (head entry); issued_cnt (popped beats, wraps).
// Build option: ILLEGAL_TRAP_EN enqueues illegal instructions flagged with
//        out_illegal; without it they are accepted and dropped.
module mips_alu_issue
    import mips_alu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_rs_val,
    input  logic [31:0]      in_rt_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [4:0]       out_rd,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issued_cnt
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    entry_t dec_ent;
    entry_t wr_ent;

    mips_alu_decode u_decode (
        .instr  (in_instr),
        .rs_val (in_rs_val),
        .rt_val (in_rt_val),
        .ent    (dec_ent)
    );

    entry_t           mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    entry_t           head_q;
    logic [CNT_W-1:0] issued_q;

    logic       accept;
    logic       push;
    logic       pop;
    entry_t     mem_nxt [2];
    logic       wr_ptr_nxt;
    logic       rd_ptr_nxt;
    logic [1:0] cnt_nxt;
    entry_t     head_nxt;

    assign accept = in_valid && in_ready_q;
    assign pop    = (cnt_q != 2'd0) && out_ready;

`ifdef ILLEGAL_TRAP_EN
    assign push   = accept;
    assign wr_ent = dec_ent;
`else
    // Illegal beats complete the handshake but never reach the buffer
    assign push = accept && !dec_ent.illegal;
    always_comb begin
        wr_ent         = dec_ent;
        wr_ent.illegal = 1'b0;
    end
`endif

    // Next buffer state; head outputs are registered from the next head slot
    always_comb begin
        mem_nxt[0] = mem_q[0];
        mem_nxt[1] = mem_q[1];
        if (push) begin
            mem_nxt[wr_ptr_q] = wr_ent;
        end
        wr_ptr_nxt = wr_ptr_q ^ push;
        rd_ptr_nxt = rd_ptr_q ^ pop;
        unique case ({push, pop})
            2'b10:   cnt_nxt = cnt_q + 2'd1;
            2'b01:   cnt_nxt = cnt_q - 2'd1;
            default: cnt_nxt = cnt_q;
        endcase
        head_nxt = (cnt_nxt != 2'd0) ? mem_nxt[rd_ptr_nxt] : '0;
    end

    // Buffer, handshake and counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            issued_q    <= '0;
        end else begin
            mem_q[0]    <= mem_nxt[0];
            mem_q[1]    <= mem_nxt[1];
            wr_ptr_q    <= wr_ptr_nxt;
            rd_ptr_q    <= rd_ptr_nxt;
            cnt_q       <= cnt_nxt;
            in_ready_q  <= (cnt_nxt < FULL);
            out_valid_q <= (cnt_nxt != 2'd0);
            head_q      <= head_nxt;
            if (pop) begin
                issued_q <= issued_q + CNT_W'(1);
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign alu_op      = head_q.op;
    assign alu_a       = head_q.a;
    assign alu_b       = head_q.b;
    assign out_rd      = head_q.rd;
    assign out_illegal = head_q.illegal;
    assign issued_cnt  = issued_q;

endmodule

// File: tb/tb_mips_alu_issue.sv
// Directed self-checking bench for mips_alu_issue.
module tb_mips_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic [15:0] issued_cnt;

    int vecs = 0;
    int errs = 0;
    int exp_issued = 0;

    mips_alu_issue #(.DEPTH(2), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs_val   (in_rs_val),
        .in_rt_val   (in_rt_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .out_rd      (out_rd),
        .out_illegal (out_illegal),
        .issued_cnt  (issued_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a beat, wait (bounded) for in_ready, complete the handshake
    task automatic send(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
        int n = 0;
        in_valid  = 1'b1;
        in_instr  = instr;
        in_rs_val = rs;
        in_rt_val = rt;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        vecs++;
        if (!in_ready) begin
            errs++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_issued++;
    endtask

    task automatic test_reset();
        logic [90:0] obs;
        step();
        step();
        obs = {out_valid, in_ready, alu_op, alu_a, alu_b, out_rd, out_illegal, issued_cnt};
        vecs++;
        if (obs !== '0) begin errs++; $display("FAIL reset_outputs: got %h required 0", obs); end
        rst_n = 1'b1;
        vecs++;
        if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_release_ready: got %0b required 0", in_ready); end
        step();
        vecs++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL ready_after_release: got %0b required 1", in_ready); end
        // fill the buffer, then reset mid-stream
        out_ready = 1'b0;
        send(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'h1, 32'h2);
        send(rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h22), 32'h5, 32'h6);
        vecs++;
        if ({out_valid, in_ready} !== 2'b10) begin
            errs++; $display("FAIL full_before_reset: valid,ready=%b required 10", {out_valid, in_ready});
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs = {out_valid, in_ready, alu_op, alu_a, alu_b, out_rd, out_illegal, issued_cnt};
        vecs++;
        if (obs !== '0) begin errs++; $display("FAIL midstream_reset: got %h required 0", obs); end
        step();
        rst_n = 1'b1;
        vecs++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errs++; $display("FAIL post_reset_idle: valid,ready=%b required 00", {out_valid, in_ready});
        end
        step();
        vecs++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errs++; $display("FAIL post_reset_ready: valid,ready=%b required 01", {out_valid, in_ready});
        end
        exp_issued = 0;
    endtask

    task automatic test_rtype_shift();
        out_ready = 1'b0;
        send(rtype(5'd9, 5'd2, 5'd7, 5'd1, 6'h00), 32'h11111111, 32'hDDDDDDDD);
        vecs++;
        if ({out_valid, alu_op, alu_a, alu_b, out_rd} !== {1'b1, 3'b000, 32'hDDDDDDDD, 32'h1, 5'd7}) begin
            errs++;
            $display("FAIL sll_decode: v=%0b op=%b a=%h b=%h rd=%0d required v=1 op=000 a=DDDDDDDD b=1 rd=7",
                     out_valid, alu_op, alu_a, alu_b, out_rd);
        end
        pop_one();
        vecs++;
        if (out_valid !== 1'b0) begin errs++; $display("FAIL sll_pop: out_valid=%0b required 0", out_valid); end
    endtask

    task automatic test_itype_ext();
        out_ready = 1'b0;
        send(itype(6'h08, 5'd1, 5'd9, 16'hFFFF), 32'h5, 32'hAAAA0000);
        vecs++;
        if ({alu_op, alu_a, alu_b, out_rd} !== {3'b010, 32'h5, 32'hFFFFFFFF, 5'd9}) begin
            errs++;
            $display("FAIL addi_sext: op=%b a=%h b=%h rd=%0d required op=010 a=5 b=FFFFFFFF rd=9",
                     alu_op, alu_a, alu_b, out_rd);
        end
        pop_one();
        send(itype(6'h0D, 5'd1, 5'd3, 16'hFFFF), 32'h1234, 32'h0);
        vecs++;
        if ({alu_op, alu_a, alu_b, out_rd} !== {3'b101, 32'h1234, 32'h0000FFFF, 5'd3}) begin
            errs++;
            $display("FAIL ori_zext: op=%b a=%h b=%h rd=%0d required op=101 a=1234 b=0000FFFF rd=3",
                     alu_op, alu_a, alu_b, out_rd);
        end
        pop_one();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(rtype(5'd1, 5'd2, 5'd1, 5'd0, 6'h24), 32'h0F0F0000, 32'h00FF00FF);
        vecs++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_ready_one: got %0b required 1", in_ready); end
        send(rtype(5'd1, 5'd2, 5'd2, 5'd0, 6'h25), 32'h0F0F0000, 32'h00FF00FF);
        vecs++;
        if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready_full: got %0b required 0", in_ready); end
        // third beat offered while full: must be held
        in_valid  = 1'b1;
        in_instr  = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h26);
        repeat (3) step();
        vecs++;
        if ({in_ready, out_valid, alu_op, out_rd} !== {1'b0, 1'b1, 3'b100, 5'd1}) begin
            errs++;
            $display("FAIL bp_hold: ready=%0b v=%0b op=%b rd=%0d required ready=0 v=1 op=100 rd=1",
                     in_ready, out_valid, alu_op, out_rd);
        end
        out_ready = 1'b1;
        step();
        vecs++;
        if ({in_ready, out_valid, alu_op, out_rd} !== {1'b1, 1'b1, 3'b101, 5'd2}) begin
            errs++;
            $display("FAIL bp_drain1: ready=%0b v=%0b op=%b rd=%0d required ready=1 v=1 op=101 rd=2",
                     in_ready, out_valid, alu_op, out_rd);
        end
        step();
        in_valid = 1'b0;
        vecs++;
        if ({out_valid, alu_op, alu_a, alu_b, out_rd} !== {1'b1, 3'b111, 32'h0F0F0000, 32'h00FF00FF, 5'd3}) begin
            errs++;
            $display("FAIL bp_drain2: v=%0b op=%b a=%h b=%h rd=%0d required v=1 op=111 rd=3",
                     out_valid, alu_op, alu_a, alu_b, out_rd);
        end
        step();
        out_ready = 1'b0;
        exp_issued += 3;
        vecs++;
        if ({out_valid, issued_cnt} !== {1'b0, 16'(exp_issued)}) begin
            errs++;
            $display("FAIL bp_issued: v=%0b cnt=%0d required v=0 cnt=%0d", out_valid, issued_cnt, exp_issued);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] ins [3];
        logic [31:0] rsv [3];
        logic [31:0] rtv [3];
        logic [2:0]  eop [3];
        logic [31:0] ea  [3];
        logic [31:0] eb  [3];
        logic [4:0]  erd [3];
        ins[0] = rtype(5'd0, 5'd4, 5'd10, 5'd4, 6'h03); rsv[0] = 32'h7; rtv[0] = 32'h80000000;
        eop[0] = 3'b001; ea[0] = 32'h80000000; eb[0] = 32'h4; erd[0] = 5'd10;
        ins[1] = rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'h22); rsv[1] = 32'd10; rtv[1] = 32'd3;
        eop[1] = 3'b011; ea[1] = 32'd10; eb[1] = 32'd3; erd[1] = 5'd11;
        ins[2] = rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h2A); rsv[2] = 32'hFFFFFFFF; rtv[2] = 32'h1;
        eop[2] = 3'b110; ea[2] = 32'hFFFFFFFF; eb[2] = 32'h1; erd[2] = 5'd12;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_instr  = ins[i];
            in_rs_val = rsv[i];
            in_rt_val = rtv[i];
            step();
            vecs++;
            if ({in_ready, out_valid, alu_op, alu_a, alu_b, out_rd} !==
                {1'b1, 1'b1, eop[i], ea[i], eb[i], erd[i]}) begin
                errs++;
                $display("FAIL stream_%0d: ready=%0b v=%0b op=%b a=%h b=%h rd=%0d required op=%b a=%h b=%h rd=%0d",
                         i, in_ready, out_valid, alu_op, alu_a, alu_b, out_rd, eop[i], ea[i], eb[i], erd[i]);
            end
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        exp_issued += 3;
        vecs++;
        if ({out_valid, issued_cnt} !== {1'b0, 16'(exp_issued)}) begin
            errs++;
            $display("FAIL stream_end: v=%0b cnt=%0d required v=0 cnt=%0d", out_valid, issued_cnt, exp_issued);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b0;
        send(itype(6'h3F, 5'd1, 5'd2, 16'h1234), 32'h55, 32'h66);
`ifdef ILLEGAL_TRAP_EN
        vecs++;
        if ({out_valid, out_illegal, alu_op, alu_a, alu_b, out_rd} !== {1'b1, 1'b1, 3'b010, 64'h0, 5'd0}) begin
            errs++;
            $display("FAIL illegal_trap: v=%0b ill=%0b op=%b a=%h b=%h rd=%0d required v=1 ill=1 op=010 a=0 b=0 rd=0",
                     out_valid, out_illegal, alu_op, alu_a, alu_b, out_rd);
        end
        pop_one();
`else
        vecs++;
        if ({out_valid, out_illegal, in_ready} !== 3'b001) begin
            errs++;
            $display("FAIL illegal_drop: v=%0b ill=%0b ready=%0b required v=0 ill=0 ready=1",
                     out_valid, out_illegal, in_ready);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
`endif
        vecs++;
        if ({out_valid, issued_cnt} !== {1'b0, 16'(exp_issued)}) begin
            errs++;
            $display("FAIL illegal_issued: v=%0b cnt=%0d required v=0 cnt=%0d", out_valid, issued_cnt, exp_issued);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_rs_val = '0;
        in_rt_val = '0;
        out_ready = 1'b0;
        test_reset();
        test_rtype_shift();
        test_itype_ext();
        test_backpressure();
        test_streaming();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
